// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write ports, read ports and status flags.
interface register_file_mp_if #(
    parameter int WORD_LENGTH = 8,
    parameter int REG_AMOUNT  = 8,
    parameter int NUM_RD      = 3,
    parameter int NUM_WR      = 2
);
    localparam int AW = $clog2(REG_AMOUNT);

    logic [NUM_WR-1:0]             wrEn;
    logic [NUM_WR*AW-1:0]          addrWrite;
    logic [NUM_WR*WORD_LENGTH-1:0] dataIn;
    logic [NUM_RD-1:0]             rdEn;
    logic [NUM_RD*AW-1:0]          addrRead;
    logic [NUM_RD*WORD_LENGTH-1:0] dataOut;
    logic [NUM_RD-1:0]             rdValid;
    logic                          wrCollision;
    logic                          addrErr;

    modport master (
        output wrEn, addrWrite, dataIn, rdEn, addrRead,
        input  dataOut, rdValid, wrCollision, addrErr
    );

    modport slave (
        input  wrEn, addrWrite, dataIn, rdEn, addrRead,
        output dataOut, rdValid, wrCollision, addrErr
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: registered reads, optional write-to-read bypass,
// highest-numbered write port wins. Option macro: REGFILE_ZERO_REG_EN (register 0 reads as zero).
module register_file_mp #(
    parameter int WORD_LENGTH = 8,
    parameter int REG_AMOUNT  = 8,
    parameter int NUM_RD      = 3,
    parameter int NUM_WR      = 2,
    parameter int BYPASS      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    register_file_mp_if.slave bus
);
    localparam int          AW        = $clog2(REG_AMOUNT);
    localparam logic [AW:0] REG_LIMIT = (AW+1)'(REG_AMOUNT);
`ifdef REGFILE_ZERO_REG_EN
    localparam int          FIRST_REG = 1;
`else
    localparam int          FIRST_REG = 0;
`endif

    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        addr_in_range = ({1'b0, addr} < REG_LIMIT);
    endfunction

    // Addresses that own storage; a hardwired zero register is not writable.
    function automatic logic addr_writable(input logic [AW-1:0] addr);
`ifdef REGFILE_ZERO_REG_EN
        addr_writable = addr_in_range(addr) && (addr != {AW{1'b0}});
`else
        addr_writable = addr_in_range(addr);
`endif
    endfunction

    logic [WORD_LENGTH-1:0]        regs_q [FIRST_REG:REG_AMOUNT-1];
    logic [WORD_LENGTH-1:0]        regs_d [FIRST_REG:REG_AMOUNT-1];
    logic [NUM_RD*WORD_LENGTH-1:0] data_out_q;
    logic [NUM_RD*WORD_LENGTH-1:0] data_out_d;
    logic [NUM_RD-1:0]             rd_valid_q;
    logic                          wr_collision_q;
    logic                          wr_collision_d;
    logic                          addr_err_q;
    logic                          addr_err_d;
    logic [WORD_LENGTH-1:0]        rd_word_s;

    // Write resolution: later (higher) ports overwrite earlier ones; also collision/error flags.
    always_comb begin
        for (int r = FIRST_REG; r < REG_AMOUNT; r++) begin
            regs_d[r] = regs_q[r];
        end
        wr_collision_d = 1'b0;
        addr_err_d     = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int r = FIRST_REG; r < REG_AMOUNT; r++) begin
                regs_d[r] = (bus.wrEn[i] && (bus.addrWrite[i*AW +: AW] == AW'(r)))
                            ? bus.dataIn[i*WORD_LENGTH +: WORD_LENGTH] : regs_d[r];
            end
            addr_err_d = addr_err_d | (bus.wrEn[i] & ~addr_in_range(bus.addrWrite[i*AW +: AW]));
            for (int k = i + 1; k < NUM_WR; k++) begin
                wr_collision_d = wr_collision_d
                               | (bus.wrEn[i] & bus.wrEn[k]
                                  & addr_writable(bus.addrWrite[i*AW +: AW])
                                  & (bus.addrWrite[i*AW +: AW] == bus.addrWrite[k*AW +: AW]));
            end
        end
        for (int j = 0; j < NUM_RD; j++) begin
            addr_err_d = addr_err_d | (bus.rdEn[j] & ~addr_in_range(bus.addrRead[j*AW +: AW]));
        end
    end

    // Read mux: unmatched (illegal or hardwired-zero) addresses fall through to zero.
    always_comb begin
        data_out_d = data_out_q;
        rd_word_s  = {WORD_LENGTH{1'b0}};
        for (int j = 0; j < NUM_RD; j++) begin
            rd_word_s = {WORD_LENGTH{1'b0}};
            for (int r = FIRST_REG; r < REG_AMOUNT; r++) begin
                rd_word_s = (bus.addrRead[j*AW +: AW] == AW'(r))
                            ? ((BYPASS != 0) ? regs_d[r] : regs_q[r]) : rd_word_s;
            end
            data_out_d[j*WORD_LENGTH +: WORD_LENGTH] = bus.rdEn[j] ? rd_word_s
                                                     : data_out_q[j*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    // State and output registers; synchronous reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = FIRST_REG; r < REG_AMOUNT; r++) begin
                regs_q[r] <= {WORD_LENGTH{1'b0}};
            end
            data_out_q     <= {(NUM_RD*WORD_LENGTH){1'b0}};
            rd_valid_q     <= {NUM_RD{1'b0}};
            wr_collision_q <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            for (int r = FIRST_REG; r < REG_AMOUNT; r++) begin
                regs_q[r] <= regs_d[r];
            end
            data_out_q     <= data_out_d;
            rd_valid_q     <= bus.rdEn;
            wr_collision_q <= wr_collision_d;
            addr_err_q     <= addr_err_d;
        end
    end

    assign bus.dataOut     = data_out_q;
    assign bus.rdValid     = rd_valid_q;
    assign bus.wrCollision = wr_collision_q;
    assign bus.addrErr     = addr_err_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: table of directed vectors on two configurations plus a modelled random phase.
module tb_register_file_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit         ZR  = 1'b1;
    localparam logic [7:0] R0V = 8'h00;
    localparam logic       R0C = 1'b0;
`else
    localparam bit         ZR  = 1'b0;
    localparam logic [7:0] R0V = 8'h88;
    localparam logic       R0C = 1'b1;
`endif

    register_file_mp_if #(.WORD_LENGTH(8), .REG_AMOUNT(8), .NUM_RD(3), .NUM_WR(2)) if_a ();
    register_file_mp_if #(.WORD_LENGTH(8), .REG_AMOUNT(6), .NUM_RD(3), .NUM_WR(2)) if_b ();

    register_file_mp #(.WORD_LENGTH(8), .REG_AMOUNT(8), .NUM_RD(3), .NUM_WR(2), .BYPASS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    register_file_mp #(.WORD_LENGTH(8), .REG_AMOUNT(6), .NUM_RD(3), .NUM_WR(2), .BYPASS(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    typedef struct {
        bit          dut;
        logic        rst;
        logic [1:0]  we;
        logic [5:0]  wa;
        logic [15:0] wd;
        logic [2:0]  re;
        logic [8:0]  ra;
        logic [23:0] exp_do;
        logic [2:0]  exp_rv;
        logic        exp_c;
        logic        exp_e;
    } vec_t;

    typedef struct {
        int          idx;
        bit          dut;
        logic [23:0] d;
        logic [2:0]  rv;
        logic        c;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input bit d, input logic r, input logic [1:0] we,
                                input logic [2:0] wa1, input logic [2:0] wa0,
                                input logic [7:0] wd1, input logic [7:0] wd0,
                                input logic [2:0] re, input logic [2:0] ra2,
                                input logic [2:0] ra1, input logic [2:0] ra0,
                                input logic [7:0] e2, input logic [7:0] e1, input logic [7:0] e0,
                                input logic [2:0] rv, input logic c, input logic e);
        vec_t v;
        v.dut = d; v.rst = r; v.we = we; v.wa = {wa1, wa0}; v.wd = {wd1, wd0};
        v.re = re; v.ra = {ra2, ra1, ra0}; v.exp_do = {e2, e1, e0};
        v.exp_rv = rv; v.exp_c = c; v.exp_e = e;
        return v;
    endfunction

    task automatic step(input vec_t v, input int idx);
        exp_t        x;
        exp_t        y;
        logic [23:0] act_do;
        logic [2:0]  act_rv;
        logic        act_c;
        logic        act_e;
        rst_n = v.rst;
        if (!v.dut) begin
            if_a.wrEn = v.we; if_a.addrWrite = v.wa; if_a.dataIn = v.wd;
            if_a.rdEn = v.re; if_a.addrRead = v.ra;
            if_b.wrEn = 2'b00; if_b.addrWrite = 6'd0; if_b.dataIn = 16'd0;
            if_b.rdEn = 3'b000; if_b.addrRead = 9'd0;
        end else begin
            if_b.wrEn = v.we; if_b.addrWrite = v.wa; if_b.dataIn = v.wd;
            if_b.rdEn = v.re; if_b.addrRead = v.ra;
            if_a.wrEn = 2'b00; if_a.addrWrite = 6'd0; if_a.dataIn = 16'd0;
            if_a.rdEn = 3'b000; if_a.addrRead = 9'd0;
        end
        x.idx = idx; x.dut = v.dut; x.d = v.exp_do; x.rv = v.exp_rv; x.c = v.exp_c; x.e = v.exp_e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        y = sb_q.pop_front();
        if (!y.dut) begin
            act_do = if_a.dataOut; act_rv = if_a.rdValid; act_c = if_a.wrCollision; act_e = if_a.addrErr;
        end else begin
            act_do = if_b.dataOut; act_rv = if_b.rdValid; act_c = if_b.wrCollision; act_e = if_b.addrErr;
        end
        n_vec++;
        if ({act_do, act_rv, act_c, act_e} !== {y.d, y.rv, y.c, y.e}) begin
            n_bad++;
            $display("FAIL vec%0d dut%0d: got dataOut=%h rdValid=%b wrCollision=%b addrErr=%b, expected %h %b %b %b",
                     y.idx, y.dut, act_do, act_rv, act_c, act_e, y.d, y.rv, y.c, y.e);
        end
    endtask

    initial begin
        vec_t       tbl[$];
        vec_t       v;
        logic [7:0] mem [8];
        logic [7:0] nxt [8];
        logic [23:0] dm;
        logic [2:0] a;
        logic       coll;

        // dut_a: 8 registers, bypass on
        tbl.push_back(mk(1'b0,1'b0,2'b11,3'd1,3'd1,8'hEE,8'hDD,3'b111,3'd7,3'd3,3'd0,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,2'b11,3'd1,3'd1,8'hEE,8'hDD,3'b111,3'd7,3'd3,3'd0,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b111,3'd7,3'd3,3'd0,8'h00,8'h00,8'h00,3'b111,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b11,3'd6,3'd3,8'h5A,8'hA5,3'b000,3'd0,3'd0,3'd0,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b011,3'd0,3'd6,3'd3,8'h00,8'h5A,8'hA5,3'b011,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b000,3'd0,3'd6,3'd3,8'h00,8'h5A,8'hA5,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b01,3'd0,3'd2,8'h00,8'h11,3'b000,3'd0,3'd0,3'd0,8'h00,8'h5A,8'hA5,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b01,3'd0,3'd2,8'h00,8'h3C,3'b001,3'd0,3'd0,3'd2,8'h00,8'h5A,8'h3C,3'b001,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b111,3'd2,3'd2,3'd2,8'h3C,8'h3C,8'h3C,3'b111,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b11,3'd5,3'd5,8'h02,8'h01,3'b000,3'd0,3'd0,3'd0,8'h3C,8'h3C,8'h3C,3'b000,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b001,3'd0,3'd0,3'd5,8'h3C,8'h3C,8'h02,3'b001,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b11,3'd4,3'd4,8'h20,8'h10,3'b010,3'd0,3'd4,3'd0,8'h3C,8'h20,8'h02,3'b010,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b11,3'd0,3'd0,8'h88,8'h77,3'b100,3'd0,3'd0,3'd0,R0V,8'h20,8'h02,3'b100,R0C,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b001,3'd0,3'd0,3'd0,R0V,8'h20,R0V,3'b001,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,2'b11,3'd3,3'd3,8'h12,8'h34,3'b111,3'd3,3'd5,3'd6,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b111,3'd3,3'd5,3'd6,8'h00,8'h00,8'h00,3'b111,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b11,3'd7,3'd1,8'h99,8'h42,3'b000,3'd0,3'd0,3'd0,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b111,3'd7,3'd1,3'd7,8'h99,8'h42,8'h99,3'b111,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,2'b00,3'd0,3'd0,8'h00,8'h00,3'b111,3'd7,3'd1,3'd7,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        // dut_b: 6 registers, bypass off
        tbl.push_back(mk(1'b1,1'b1,2'b01,3'd0,3'd2,8'h00,8'h11,3'b000,3'd0,3'd0,3'd0,8'h00,8'h00,8'h00,3'b000,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,2'b01,3'd0,3'd2,8'h00,8'h3C,3'b001,3'd0,3'd0,3'd2,8'h00,8'h00,8'h11,3'b001,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b001,3'd0,3'd0,3'd2,8'h00,8'h00,8'h3C,3'b001,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,2'b01,3'd0,3'd7,8'h00,8'hFF,3'b010,3'd0,3'd6,3'd0,8'h00,8'h00,8'h3C,3'b010,1'b0,1'b1));
        tbl.push_back(mk(1'b1,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b111,3'd5,3'd3,3'd1,8'h00,8'h00,8'h00,3'b111,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,2'b11,3'd4,3'd4,8'h02,8'h01,3'b001,3'd0,3'd0,3'd4,8'h00,8'h00,8'h00,3'b001,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b1,2'b00,3'd0,3'd0,8'h00,8'h00,3'b001,3'd0,3'd0,3'd4,8'h00,8'h00,8'h02,3'b001,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,2'b00,3'd0,3'd7,8'h00,8'h00,3'b000,3'd7,3'd7,3'd7,8'h00,8'h00,8'h02,3'b000,1'b0,1'b0));

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k], k);
        end

        // Random traffic on dut_a against a behavioural model; dut_a was last reset and idle since.
        for (int r = 0; r < 8; r++) begin
            mem[r] = 8'h00;
        end
        dm = 24'h000000;
        for (int n = 0; n < 60; n++) begin
            v.dut = 1'b0;
            v.rst = 1'b1;
            v.we  = 2'($urandom_range(0, 3));
            v.wa  = 6'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                v.wa[5:3] = v.wa[2:0];
            end
            v.wd  = 16'($urandom);
            v.re  = 3'($urandom);
            v.ra  = 9'($urandom);
            nxt = mem;
            for (int i = 0; i < 2; i++) begin
                a = v.wa[i*3 +: 3];
                if (v.we[i] && !(ZR && (a == 3'd0))) begin
                    nxt[a] = v.wd[i*8 +: 8];
                end
            end
            coll = (v.we == 2'b11) && (v.wa[2:0] == v.wa[5:3]) && !(ZR && (v.wa[2:0] == 3'd0));
            for (int j = 0; j < 3; j++) begin
                a = v.ra[j*3 +: 3];
                if (v.re[j]) begin
                    dm[j*8 +: 8] = (ZR && (a == 3'd0)) ? 8'h00 : nxt[a];
                end
            end
            v.exp_do = dm;
            v.exp_rv = v.re;
            v.exp_c  = coll;
            v.exp_e  = 1'b0;
            mem = nxt;
            step(v, 100 + n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port register file: NUM_WR write ports, NUM_RD read ports, configurable width and depth.
- Registered reads with per-port read enable and valid flag.
- Optional same-cycle write-to-read bypass.
- Deterministic priority on write-write collisions.
- Sits in datapath/CPU cores as the architectural register store; drives operand buses one cycle after address issue.

Parameters:
WORD_LENGTH, 8, data word width in bits (>=1)
REG_AMOUNT, 8, number of registers (>=2; need not be a power of two)
NUM_RD, 3, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
BYPASS, 1, 1 = a read sees data written in the same cycle; 0 = a read sees the pre-write contents
AW, $clog2(REG_AMOUNT), derived address width; not to be overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
wrEn  input  NUM_WR  per-write-port enable
addrWrite  input  NUM_WR*AW  write addresses; port i at bits [i*AW +: AW]
dataIn  input  NUM_WR*WORD_LENGTH  write data; port i at [i*WORD_LENGTH +: WORD_LENGTH]
rdEn  input  NUM_RD  per-read-port enable
addrRead  input  NUM_RD*AW  read addresses; port j at [j*AW +: AW]
dataOut  output  NUM_RD*WORD_LENGTH  registered read data; port j at [j*WORD_LENGTH +: WORD_LENGTH]
rdValid  output  NUM_RD  high one cycle after an accepted read on port j
wrCollision  output  1  registered; high one cycle after >=2 enabled write ports target the same address
addrErr  output  1  registered; high one cycle after any enabled port presents an address >= REG_AMOUNT

Behaviour:
Reset (rst_n low at rising clk):
- All registers, dataOut, rdValid, wrCollision and addrErr become 0.
- Reset overrides all writes and reads in that cycle.
- Reset asserted mid-operation discards in-flight reads: rdValid goes 0 on the next edge.

Write:
- On the rising edge, each port i with wrEn[i]=1 and a legal address stores dataIn[i].
- Collision priority: highest-numbered port wins. Losing writes are dropped. wrCollision=1 on the next cycle.
- An illegal address (>= REG_AMOUNT) is ignored and sets addrErr=1 on the next cycle. Registers are unchanged.

Read (latency 1):
- If rdEn[j]=1 at edge N, then at edge N: dataOut[j] <= the contents of addrRead[j], and rdValid[j] <= 1.
- If rdEn[j]=0, dataOut[j] holds its previous value and rdValid[j] <= 0.
- An illegal read address returns 0, asserts rdValid, and sets addrErr.

Same-cycle read/write to the same address:
- BYPASS=1: dataOut returns the winning write data (after priority resolution).
- BYPASS=0: dataOut returns the old contents.

Other rules:
- Any number of read ports may target the same address simultaneously; each returns identical data.
- wrCollision and addrErr are single-cycle pulses, re-evaluated every cycle; they are not sticky.
- No combinational path exists from any input to any output.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero. Writes to address 0 are silently discarded and do not count toward wrCollision. Reads of address 0 return 0 regardless of BYPASS. No storage is inferred for register 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset and readback: hold rst_n=0 for 2 cycles, then rdEn on all ports to addresses 0,3,7 -> dataOut all 0x00; rdValid=3'b111 one cycle after rdEn.
2. Basic write/read: write 0xA5 to reg 3 (port 0) and 0x5A to reg 6 (port 1) in the same cycle; read 3 and 6 on the next cycle -> 0xA5 and 0x5A with latency exactly 1; rdEn=0 on the following cycle -> data held, rdValid=0.
3. Bypass: BYPASS=1, write 0x3C to reg 2 while port 0 reads reg 2 (old value 0x11) -> dataOut=0x3C. Repeat with BYPASS=0 -> dataOut=0x11, then 0x3C on the next read.
4. Collision: port 0 writes 0x01 and port 1 writes 0x02 to reg 5 in the same cycle -> reg 5=0x02, wrCollision pulses high for exactly 1 cycle.
5. Illegal address: REG_AMOUNT=6, write 0xFF to address 7 and read address 6 -> no register changes, read returns 0x00, addrErr pulses for 1 cycle.
6. Zero register and mid-operation reset:
   - With REGFILE_ZERO_REG_EN defined, write 0x77 to reg 0 and read it -> 0x00, no wrCollision when two ports both write reg 0.
   - Assert rst_n=0 in the same cycle as rdEn=1 -> rdValid=0 and dataOut=0 on the next cycle.
